// File: rtl/param_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : param_rr_arbiter
//  Description : N-way arbiter with run-time selectable fixed-priority or
//                round-robin mode and a bounded grant-hold time. The grant is
//                registered and one-hot. The owner keeps the grant while it
//                keeps requesting, for up to MAX_HOLD cycles. After that it is
//                pre-empted if another requester is waiting.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_rr_arbiter #(
    parameter  int NUM_REQ  = 5,
    parameter  int MAX_HOLD = 8,
    localparam int ID_W     = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clock,
    input  logic               reset,      // synchronous, active-low
    input  logic               mode,       // 0 = fixed priority, 1 = round-robin
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id
);

    // Counter wide enough to hold the value MAX_HOLD.
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;

    localparam logic [CNT_W-1:0] c_HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] c_HOLD_ONE = CNT_W'(1);
    localparam logic [ID_W-1:0]  c_PTR_RST  = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]    c_NUM_EXT  = (ID_W + 1)'(NUM_REQ);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  w_gnt_nxt;
    logic [ID_W-1:0]     r_gnt_id;
    logic [ID_W-1:0]     w_gnt_id_nxt;
    logic                r_gnt_valid;
    logic                w_gnt_valid_nxt;
    logic [CNT_W-1:0]    r_hold_cnt;
    logic [CNT_W-1:0]    w_hold_nxt;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     w_rr_ptr_nxt;

    logic [ID_W-1:0]     w_win_all;
    logic [ID_W-1:0]     w_win_pre;
    logic                w_any_req;
    logic                w_own_req;
    logic                w_others_req;

    // Arbitration: in fixed mode the lowest set index wins; in round-robin
    // mode the search starts just after ptr and wraps modulo NUM_REQ.
    // The wrap uses a single conditional subtract because ptr+1+k < 2*NUM_REQ.
    function automatic logic [ID_W-1:0] f_arb(
        input logic [NUM_REQ-1:0] v,
        input logic               rr,
        input logic [ID_W-1:0]    ptr
    );
        logic [ID_W-1:0] win;
        logic [ID_W-1:0] idx;
        logic [ID_W:0]   sum;
        logic            found;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (rr) begin
                sum = {1'b0, ptr} + (ID_W + 1)'(k + 1);
                if (sum >= c_NUM_EXT) begin
                    sum = sum - c_NUM_EXT;
                end
                idx = sum[ID_W-1:0];
            end else begin
                idx = ID_W'(k);
            end
            if (!found && v[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return win;
    endfunction

    // Winner candidates and request summaries used by the next-state logic.
    always_comb begin
        w_any_req    = |req;
        w_own_req    = |(req & r_gnt);
        w_others_req = |(req & ~r_gnt);
        w_win_all    = f_arb(req, mode, r_rr_ptr);
        w_win_pre    = f_arb(req & ~r_gnt, mode, r_rr_ptr);
    end

    // Next-state and next-grant decision; every path defaults to "hold".
    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_gnt_id_nxt    = r_gnt_id;
        w_gnt_valid_nxt = r_gnt_valid;
        w_hold_nxt      = r_hold_cnt;
        w_rr_ptr_nxt    = r_rr_ptr;

        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt     = S_GRANT;
                    w_gnt_nxt       = NUM_REQ'(1) << w_win_all;
                    w_gnt_id_nxt    = w_win_all;
                    w_gnt_valid_nxt = 1'b1;
                    w_hold_nxt      = c_HOLD_ONE;
                    w_rr_ptr_nxt    = w_win_all;
                end
            end

            S_GRANT: begin
                if (!w_own_req) begin
                    // Owner released: hand over on the same edge when possible
                    // so there is no idle bubble between owners.
                    if (w_any_req) begin
                        w_gnt_nxt       = NUM_REQ'(1) << w_win_all;
                        w_gnt_id_nxt    = w_win_all;
                        w_gnt_valid_nxt = 1'b1;
                        w_hold_nxt      = c_HOLD_ONE;
                        w_rr_ptr_nxt    = w_win_all;
                    end else begin
                        w_state_nxt     = S_IDLE;
                        w_gnt_nxt       = '0;
                        w_gnt_id_nxt    = '0;
                        w_gnt_valid_nxt = 1'b0;
                        w_hold_nxt      = '0;
                    end
                end else if (r_hold_cnt < c_HOLD_MAX) begin
                    w_hold_nxt = r_hold_cnt + c_HOLD_ONE;
                end else if (w_others_req) begin
                    // Hold limit reached with someone waiting: the owner is
                    // excluded from this round.
                    w_gnt_nxt       = NUM_REQ'(1) << w_win_pre;
                    w_gnt_id_nxt    = w_win_pre;
                    w_gnt_valid_nxt = 1'b1;
                    w_hold_nxt      = c_HOLD_ONE;
                    w_rr_ptr_nxt    = w_win_pre;
                end else begin
                    // Nobody else wants the resource: keep it, restart count.
                    w_hold_nxt = c_HOLD_ONE;
                end
            end

            default: begin
                w_state_nxt     = S_IDLE;
                w_gnt_nxt       = '0;
                w_gnt_id_nxt    = '0;
                w_gnt_valid_nxt = 1'b0;
                w_hold_nxt      = '0;
                w_rr_ptr_nxt    = c_PTR_RST;
            end
        endcase
    end

    // State and registered outputs; reset forces idle even mid-grant.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_hold_cnt  <= '0;
            r_rr_ptr    <= c_PTR_RST;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_gnt_valid;
    assign gnt_id    = r_gnt_id;

endmodule
`default_nettype wire

// File: tb/tb_param_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_rr_arbiter
//  Description : Self-checking bench for param_rr_arbiter (NUM_REQ=5,
//                MAX_HOLD=4). Expected grants are queued when stimulus is
//                driven and compared after the following clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_rr_arbiter;

    localparam int N     = 5;
    localparam int MH    = 4;
    localparam int IW    = 3;
    localparam int BOUND = (N - 1) * MH + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          mode  = 1'b0;
    logic [N-1:0]  req   = '0;
    wire  [N-1:0]  gnt;
    wire           gnt_valid;
    wire  [IW-1:0] gnt_id;

    always #5 clock = ~clock;

    param_rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .mode      (mode),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [N-1:0] sb_q[$];

    // Reference model state: owner index (-1 when idle), hold count, pointer.
    int m_own  = -1;
    int m_hold = 0;
    int m_ptr  = N - 1;

    int  miss[N];
    bit  rr_phase = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_arb(input logic [N-1:0] v, input logic rr, input int ptr);
        int i;
        for (int k = 0; k < N; k++) begin
            i = rr ? (ptr + 1 + k) % N : k;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_gnt();
        logic [N-1:0] g;
        g = '0;
        if (m_own >= 0) g[m_own] = 1'b1;
        return g;
    endfunction

    function automatic int idx_of(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return 0;
    endfunction

    task automatic m_step(input logic rn, input logic md, input logic [N-1:0] r);
        logic [N-1:0] oth;
        int w;
        if (!rn) begin
            m_own = -1; m_hold = 0; m_ptr = N - 1;
        end else if (m_own < 0) begin
            w = m_arb(r, md, m_ptr);
            if (w >= 0) begin m_own = w; m_hold = 1; m_ptr = w; end
        end else if (!r[m_own]) begin
            w = m_arb(r, md, m_ptr);
            if (w >= 0) begin m_own = w; m_hold = 1; m_ptr = w; end
            else begin m_own = -1; m_hold = 0; end
        end else if (m_hold < MH) begin
            m_hold++;
        end else begin
            oth = r;
            oth[m_own] = 1'b0;
            if (oth != 0) begin
                w = m_arb(oth, md, m_ptr);
                m_own = w; m_hold = 1; m_ptr = w;
            end else begin
                m_hold = 1;
            end
        end
    endtask

    // One clock cycle: drive, queue expectation, wait for edge, compare.
    // With dir=1 the queued value is the directed constant, otherwise the model.
    task automatic cyc(input logic rn, input logic md, input logic [N-1:0] r,
                       input bit dir, input logic [N-1:0] dexp, input string tag);
        logic [N-1:0] e;
        reset = rn;
        mode  = md;
        req   = rn ? r : 'x;
        m_step(rn, md, r);
        sb_q.push_back(dir ? dexp : m_gnt());
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        chk({tag, "_gnt"}, 32'(gnt), 32'(e));
        chk({tag, "_vld"}, 32'(gnt_valid), 32'(|e));
        chk({tag, "_id"}, 32'(gnt_id), 32'(idx_of(e)));
        chk({tag, "_onehot"}, 32'($onehot0(gnt)), 32'd1);
        for (int i = 0; i < N; i++) begin
            if (rr_phase && rn && r[i]) begin
                if (gnt[i]) begin
                    chk("starve_grant", 32'(miss[i] + 1 <= BOUND), 32'd1);
                    miss[i] = 0;
                end else begin
                    miss[i]++;
                    if (miss[i] >= BOUND) chk("starve_wait", 32'(miss[i]), 32'(BOUND - 1));
                end
            end else begin
                miss[i] = 0;
            end
        end
    endtask

    initial begin
        logic [N-1:0] r;
        logic         md;

        // 1. reset with all requesting, then first grant in fixed mode
        cyc(1'b0, 1'b0, 5'b11111, 1, 5'b00000, "t1_rst");
        cyc(1'b0, 1'b0, 5'b11111, 1, 5'b00000, "t1_rst");
        cyc(1'b1, 1'b0, 5'b11111, 1, 5'b00001, "t1_first");

        // 2. fixed priority with hold limit: 1 and 2 alternate, 4 starves
        cyc(1'b0, 1'b0, 5'b00000, 1, 5'b00000, "t2_rst");
        for (int c = 0; c < 16; c++)
            cyc(1'b1, 1'b0, 5'b10110, 1, ((c / 4) % 2 == 0) ? 5'b00010 : 5'b00100, "t2_fix");

        // 3. round-robin rotation, four cycles each, then wrap
        cyc(1'b0, 1'b1, 5'b00000, 1, 5'b00000, "t3_rst");
        for (int c = 0; c < 20; c++)
            cyc(1'b1, 1'b1, 5'b11111, 1, N'(1) << (c / 4), "t3_rr");
        cyc(1'b1, 1'b1, 5'b11111, 1, 5'b00001, "t3_wrap");

        // 4. release hands over without a bubble
        cyc(1'b0, 1'b0, 5'b00000, 1, 5'b00000, "t4_rst");
        cyc(1'b1, 1'b0, 5'b00011, 1, 5'b00001, "t4_own");
        cyc(1'b1, 1'b0, 5'b00011, 1, 5'b00001, "t4_own");
        cyc(1'b1, 1'b0, 5'b00010, 1, 5'b00010, "t4_hand");
        cyc(1'b1, 1'b0, 5'b00010, 1, 5'b00010, "t4_hand");

        // 5. lone requester keeps the grant past the hold limit, then idles
        cyc(1'b0, 1'b0, 5'b00000, 1, 5'b00000, "t5_rst");
        for (int c = 0; c < 10; c++)
            cyc(1'b1, 1'b0, 5'b00100, 1, 5'b00100, "t5_lone");
        cyc(1'b1, 1'b0, 5'b00000, 1, 5'b00000, "t5_idle");

        // 6. reset mid-grant of requester 3 restores the RR pointer
        cyc(1'b0, 1'b1, 5'b00000, 1, 5'b00000, "t6_rst");
        for (int c = 0; c < 13; c++)
            cyc(1'b1, 1'b1, 5'b11111, 1, N'(1) << (c / 4), "t6_rr");
        cyc(1'b1, 1'b1, 5'b11111, 1, 5'b01000, "t6_own3");
        cyc(1'b0, 1'b1, 5'b11111, 1, 5'b00000, "t6_midrst");
        cyc(1'b1, 1'b1, 5'b11111, 1, 5'b00001, "t6_after");

        // 7. mode change mid-grant: owner kept, new mode used at pre-emption
        cyc(1'b0, 1'b1, 5'b00000, 1, 5'b00000, "t7_rst");
        cyc(1'b1, 1'b1, 5'b01010, 1, 5'b00010, "t7_own");
        cyc(1'b1, 1'b1, 5'b01010, 1, 5'b00010, "t7_own");
        cyc(1'b1, 1'b0, 5'b01011, 1, 5'b00010, "t7_modechg");
        cyc(1'b1, 1'b0, 5'b01011, 1, 5'b00010, "t7_modechg");
        cyc(1'b1, 1'b0, 5'b01011, 1, 5'b00001, "t7_preempt");

        // 8. round-robin starvation run: requests stay up until served
        cyc(1'b0, 1'b1, 5'b00000, 1, 5'b00000, "t8_rst");
        rr_phase = 1'b1;
        r = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (r[i] && m_own == i && $urandom_range(2) == 0) r[i] = 1'b0;
                else if (!r[i] && $urandom_range(3) == 0)         r[i] = 1'b1;
            end
            cyc(1'b1, 1'b1, r, 0, '0, "t8_rr");
        end
        rr_phase = 1'b0;

        // 9. mixed random: random requests, mode and occasional reset
        for (int c = 0; c < 300; c++) begin
            r  = N'($urandom);
            md = 1'($urandom);
            cyc(($urandom_range(19) != 0), md, r, 0, '0, "t9_rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
